// File: rtl/iir_coeff_loader.sv
// IIR biquad coefficient loader: GPIO-written shadow bank, atomic transfer to the active bank on a sample tick.
// Optional stability screening of a1/a2 is enabled by defining IIR_COEFF_STABILITY_CHECK_EN.
module iir_coeff_loader #(
    parameter int COEFF_WIDTH = 32,
    parameter int LOG_A0      = COEFF_WIDTH - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             gpio_addr,
    input  logic [COEFF_WIDTH-1:0] gpio_data,
    input  logic                   gpio_we,
    input  logic                   commit,
    input  logic                   sample_tick,
    output logic [COEFF_WIDTH-1:0] b0,
    output logic [COEFF_WIDTH-1:0] b1,
    output logic [COEFF_WIDTH-1:0] b2,
    output logic [COEFF_WIDTH-1:0] a1,
    output logic [COEFF_WIDTH-1:0] a2,
    output logic [COEFF_WIDTH-1:0] gain,
    output logic                   busy,
    output logic                   commit_ack,
    output logic                   reject,
    output logic                   wr_drop
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        PENDING
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [COEFF_WIDTH-1:0] shadow [6];

    logic we_ok;
    logic we_drop;
    logic xfer;

`ifdef IIR_COEFF_STABILITY_CHECK_EN
    localparam int XW = COEFF_WIDTH + 2;
    localparam logic signed [XW-1:0] A0 = {{(XW-1){1'b0}}, 1'b1} << LOG_A0;

    logic signed [XW-1:0] a1_x;
    logic signed [XW-1:0] a2_x;
    logic signed [XW-1:0] a1_abs;
    logic signed [XW-1:0] a2_abs;
    logic                 check_pass;
    logic                 rej_nxt;

    // Two guard bits keep |most-negative| and A0 + a2 free of overflow.
    always_comb begin
        a1_x       = $signed({{2{shadow[3][COEFF_WIDTH-1]}}, shadow[3]});
        a2_x       = $signed({{2{shadow[4][COEFF_WIDTH-1]}}, shadow[4]});
        a1_abs     = a1_x[XW-1] ? -a1_x : a1_x;
        a2_abs     = a2_x[XW-1] ? -a2_x : a2_x;
        check_pass = (a2_abs < A0) && (a1_abs < (A0 + a2_x));
    end
`endif

    always_comb begin
        state_nxt = state;
        we_ok     = 1'b0;
        we_drop   = 1'b0;
        xfer      = 1'b0;
`ifdef IIR_COEFF_STABILITY_CHECK_EN
        rej_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (gpio_we) begin
                    if (gpio_addr <= 3'd5) we_ok = 1'b1;
                    else                   we_drop = 1'b1;
                end
                if (commit) state_nxt = CHECK;
            end
            CHECK: begin
                we_drop = gpio_we;
`ifdef IIR_COEFF_STABILITY_CHECK_EN
                if (check_pass) begin
                    state_nxt = PENDING;
                end else begin
                    state_nxt = IDLE;
                    rej_nxt   = 1'b1;
                end
`else
                state_nxt = PENDING;
`endif
            end
            PENDING: begin
                we_drop = gpio_we;
                if (sample_tick) begin
                    xfer      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 6; i++) shadow[i] <= '0;
        end else if (we_ok) begin
            for (int unsigned i = 0; i < 6; i++)
                if (gpio_addr == 3'(i)) shadow[i] <= gpio_data;
        end
    end

    // All six active words move on the same edge so the filter never sees a mixed bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            b0   <= '0;
            b1   <= '0;
            b2   <= '0;
            a1   <= '0;
            a2   <= '0;
            gain <= '0;
        end else if (xfer) begin
            b0   <= shadow[0];
            b1   <= shadow[1];
            b2   <= shadow[2];
            a1   <= shadow[3];
            a2   <= shadow[4];
            gain <= shadow[5];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_ack <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            commit_ack <= xfer;
            wr_drop    <= we_drop;
        end
    end

`ifdef IIR_COEFF_STABILITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) reject <= 1'b0;
        else     reject <= rej_nxt;
    end
`else
    assign reject = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Scoreboard bench for iir_coeff_loader: stimulus queues expected pulses, a negedge monitor retires them.
module tb_iir_coeff_loader;

    localparam logic [1:0] K_ACK  = 2'd0;
    localparam logic [1:0] K_REJ  = 2'd1;
    localparam logic [1:0] K_DROP = 2'd2;

    typedef struct packed {
        logic [1:0]       kind;
        logic [5:0][31:0] bank;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  gpio_addr = '0;
    logic [31:0] gpio_data = '0;
    logic        gpio_we = 1'b0;
    logic        commit = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] b0, b1, b2, a1, a2, gain;
    logic        busy, commit_ack, reject, wr_drop;

    int tests = 0;
    int failed = 0;
    exp_t q[$];
    logic [5:0][31:0] sh = '0;
    logic [5:0][31:0] act_m = '0;
    logic [5:0][31:0] act;

    assign act = {gain, a2, a1, b2, b1, b0};

    iir_coeff_loader #(.COEFF_WIDTH(32), .LOG_A0(30)) dut (
        .clk(clk), .rst(rst), .gpio_addr(gpio_addr), .gpio_data(gpio_data),
        .gpio_we(gpio_we), .commit(commit), .sample_tick(sample_tick),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .gain(gain),
        .busy(busy), .commit_ack(commit_ack), .reject(reject), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [191:0] actual, input logic [191:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic push(input logic [1:0] k);
        exp_t e;
        e.kind = k;
        e.bank = sh;
        q.push_back(e);
    endtask

    task automatic pop(input logic [1:0] k);
        exp_t e;
        tests++;
        if (q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_pulse: got kind %0d expected no pulse", k);
        end else begin
            e = q.pop_front();
            if (e.kind != k) begin
                failed++;
                $display("FAIL pulse_kind: got %0d expected %0d", k, e.kind);
            end else if (k == K_ACK && act !== e.bank) begin
                failed++;
                $display("FAIL ack_bank: got %h expected %h", act, e.bank);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (commit_ack) pop(K_ACK);
            if (reject)     pop(K_REJ);
            if (wr_drop)    pop(K_DROP);
        end
    end

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        gpio_we = 1'b1; gpio_addr = addr; gpio_data = data;
        step();
        gpio_we = 1'b0;
        if (addr <= 3'd5) sh[addr] = data;
    endtask

    // commit, then clock through CHECK; caller handles the outcome
    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
    endtask

    task automatic tick_xfer(input string name);
        push(K_ACK);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        act_m = sh;
        chk(name, act, act_m);
    endtask

    task automatic expect_reject(input string name);
        push(K_REJ);
        do_commit();
        chk({name, "_busy"}, busy, 0);
        chk({name, "_hold"}, act, act_m);
    endtask

    initial begin
        // reset
        repeat (3) step();
        chk("reset_outputs", act, '0);
        chk("reset_flags", {busy, commit_ack, reject, wr_drop}, '0);
        rst = 1'b0;
        step();

        // basic load, tick 5 cycles after commit
        wr(3'd0, 32'h4000_0000);
        chk("b0_before_commit", b0, 0);
        do_commit();
        chk("busy_pending", busy, 1);
        repeat (3) begin
            step();
            chk("b0_waiting", b0, 0);
        end
        tick_xfer("b0_loaded");
        chk("busy_after_xfer", busy, 0);

        // tick coincident with commit is ignored; commit in PENDING ignored
        wr(3'd1, 32'h1111_1111);
        commit = 1'b1; sample_tick = 1'b1;
        step();
        commit = 1'b0; sample_tick = 1'b0;
        step();
        chk("no_xfer_on_commit_tick", act, act_m);
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (7) step();
        chk("still_pending", {busy, b1}, {1'b1, 32'h0});
        tick_xfer("second_tick_xfer");

        // write landing in the commit cycle, drops in PENDING and for unmapped addr
        wr(3'd3, 32'h0A00_0000);
        gpio_we = 1'b1; gpio_addr = 3'd2; gpio_data = 32'h2222_2222;
        sh[2] = 32'h2222_2222;
        commit = 1'b1;
        step();
        gpio_we = 1'b0; commit = 1'b0;
        step();
        push(K_DROP);
        gpio_we = 1'b1; gpio_addr = 3'd3; gpio_data = 32'h7FFF_FFFF;
        step();
        gpio_we = 1'b0;
        step();
        tick_xfer("xfer_with_same_cycle_write");
        push(K_DROP);
        gpio_we = 1'b1; gpio_addr = 3'd7; gpio_data = 32'h1234_5678;
        step();
        gpio_we = 1'b0;
        step();
        chk("a1_after_drops", a1, 32'h0A00_0000);
        do_commit();
        tick_xfer("recommit_same_shadow");

`ifdef IIR_COEFF_STABILITY_CHECK_EN
        wr(3'd4, 32'h4000_0000);
        expect_reject("rej_a2_limit");
        wr(3'd4, 32'h2000_0000);
        wr(3'd3, 32'h5000_0000);
        do_commit();
        step();
        tick_xfer("accept_triangle");
        wr(3'd3, 32'h6000_0000);
        expect_reject("rej_a1_edge");
        wr(3'd3, 32'hB000_0000);
        wr(3'd4, 32'hC000_0000);
        expect_reject("rej_a2_neg");
        wr(3'd4, 32'h2000_0000);
        do_commit();
        tick_xfer("accept_neg_a1");
`else
        wr(3'd4, 32'h4000_0000);
        do_commit();
        chk("no_check_busy", busy, 1);
        tick_xfer("accept_unchecked");
`endif

        // reset in PENDING aborts everything
        wr(3'd5, 32'h7FFF_FFFF);
        do_commit();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sh = '0;
        act_m = '0;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        chk("abort_outputs", act, '0);
        chk("abort_busy", busy, 0);
        do_commit();
        tick_xfer("shadow_cleared");

        repeat (4) step();
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
